// File: rtl/vram_arbiter_pkg.sv
// Shared defaults, FSM state encoding and read-return owner tags for the
// VRAM arbiter.
package vram_pkg;

  localparam int AW_DEF       = 10;
  localparam int DW_DEF       = 8;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,   // visible area: scanout has priority
    BLANK  = 2'd1,   // blanking: game logic has priority
    FORCE  = 2'd2    // game logic starved: it wins the next grant
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2
  } owner_e;

  // Owner of the read data that a grant will return; writes return nothing.
  function automatic owner_e read_owner(input logic disp_gnt,
                                        input logic cpu_gnt,
                                        input logic cpu_we);
    owner_e tag;
    if (disp_gnt) begin
      tag = DISP;
    end else if (cpu_gnt && !cpu_we) begin
      tag = CPU;
    end else begin
      tag = NONE;
    end
    return tag;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and VRAM bus bundle. The arbiter uses the slave modport; the
// requesters plus memory side use the master modport.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          vblank;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vblank,
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vblank,
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_starve_cnt.sv
// Game-logic starvation counter: counts cycles the cpu request has waited,
// saturating at MAX_WAIT. reach_max flags the edge on which the count
// arrives at MAX_WAIT, so the arbiter can force the cpu in on the very next
// cycle and the cpu never waits more than MAX_WAIT cycles.
module vram_starve_cnt #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic cpu_gnt,
  output logic reach_max
);

  localparam int            CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;

  // Next count: grow while waiting, hold at the ceiling, clear otherwise.
  always_comb begin
    count_d = '0;
    if (cpu_req && !cpu_gnt) begin
      if (count_q == MAX_C) begin
        count_d = count_q;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = '0;
    end
  end

  assign reach_max = (count_d == MAX_C);

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between display scanout and game logic.
// Grants are combinational; the granted access is registered onto the
// memory port one cycle later and read data returns one cycle after that,
// routed back by a two-stage owner tag pipeline.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic          clk,
  input logic          reset_n,
  vram_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic          disp_gnt_s, cpu_gnt_s, force_s;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  owner_e        tag1_q, tag1_d, tag2_q, tag2_d;

  vram_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (bus.cpu_req),
    .cpu_gnt   (cpu_gnt_s),
    .reach_max (force_s)
  );

  // Grant decision: a lone requester always wins; on contention the state
  // picks the winner. Nothing is granted while reset is held.
  always_comb begin
    disp_gnt_s = 1'b0;
    cpu_gnt_s  = 1'b0;
    if (!reset_n) begin
      disp_gnt_s = 1'b0;
      cpu_gnt_s  = 1'b0;
    end else if (bus.disp_req && bus.cpu_req) begin
      if (state_q == ACTIVE) begin
        disp_gnt_s = 1'b1;
      end else begin
        cpu_gnt_s = 1'b1;
      end
    end else if (bus.disp_req) begin
      disp_gnt_s = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else begin
      disp_gnt_s = 1'b0;
      cpu_gnt_s  = 1'b0;
    end
  end

  // Next state: blanking overrides everything; FORCE lasts for one cpu grant.
  always_comb begin
    state_d = state_q;
    if (bus.vblank) begin
      state_d = BLANK;
    end else begin
      case (state_q)
        ACTIVE:  state_d = force_s ? FORCE : ACTIVE;
        BLANK:   state_d = ACTIVE;
        FORCE:   state_d = cpu_gnt_s ? ACTIVE : FORCE;
        default: state_d = ACTIVE;
      endcase
    end
  end

  // Memory command and owner tag for the access granted this cycle.
  always_comb begin
    mem_en_d    = disp_gnt_s | cpu_gnt_s;
    mem_we_d    = cpu_gnt_s & bus.cpu_we;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (cpu_gnt_s) begin
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
    end else if (disp_gnt_s) begin
      mem_addr_d  = bus.disp_addr;
      mem_wdata_d = '0;
    end else begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
    tag1_d = read_owner(disp_gnt_s, cpu_gnt_s, bus.cpu_we);
    tag2_d = tag1_q;
  end

  // State, memory port and tag registers; reset drops any in-flight returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACTIVE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag1_q      <= NONE;
      tag2_q      <= NONE;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  assign bus.disp_gnt    = disp_gnt_s;
  assign bus.cpu_gnt     = cpu_gnt_s;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_rvalid = (tag2_q == DISP);
  assign bus.cpu_rvalid  = (tag2_q == CPU);
  assign bus.disp_rdata  = (tag2_q == DISP) ? bus.mem_rdata : '0;
  assign bus.cpu_rdata   = (tag2_q == CPU)  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a behavioural VRAM and
// a transaction-level reference model, plus directed scenario checks.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MW = 16;
  localparam int M_ACT = 0;
  localparam int M_BLK = 1;
  localparam int M_FRC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Behavioural single-port VRAM, one-cycle read latency.
  logic [DW-1:0] vram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= vram[bus.mem_addr];
    end
  end

  typedef struct packed {
    bit v; bit we; bit cpu; int addr; int wdata; int rdata;
  } acc_t;
  typedef struct packed {
    bit dg; bit cg; acc_t mem; bit drv; bit crv; int rdata;
  } exp_t;

  exp_t exp_q[$];
  int   ref_mem [0:31];
  acc_t h1, h2;          // accesses granted one and two cycles ago
  int   mode, waited;
  int   checks = 0, errors = 0;

  bit vb, d_pend, c_pend, c_we;
  int d_addr, c_addr, c_wd;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive pending requests, predict this cycle's outcome.
  task automatic step(input bit rst_v);
    acc_t cur;
    exp_t e;
    bit   dg, cg;
    @(posedge clk); #1;
    reset_n       = rst_v;
    bus.vblank    = vb;
    bus.disp_req  = d_pend;
    bus.disp_addr = AW'(d_addr);
    bus.cpu_req   = c_pend;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = AW'(c_addr);
    bus.cpu_wdata = DW'(c_wd);
    cur = '0;
    e   = '0;
    if (!rst_v) begin
      h1 = '0; h2 = '0; mode = M_ACT; waited = 0;
    end else begin
      dg = d_pend && !(c_pend && mode != M_ACT);
      cg = c_pend && !dg;
      if (dg) begin
        cur.v = 1'b1; cur.addr = d_addr; cur.rdata = ref_mem[d_addr];
      end
      if (cg) begin
        cur.v = 1'b1; cur.cpu = 1'b1; cur.we = c_we;
        cur.addr = c_addr; cur.wdata = c_wd;
        if (c_we) ref_mem[c_addr] = c_wd;
        else      cur.rdata = ref_mem[c_addr];
      end
      e.dg = dg; e.cg = cg; e.mem = h1;
      e.drv = h2.v && !h2.we && !h2.cpu;
      e.crv = h2.v && !h2.we && h2.cpu;
      e.rdata = h2.rdata;
      h2 = h1; h1 = cur;
      waited = (c_pend && !cg) ? ((waited + 1 > MW) ? MW : waited + 1) : 0;
      if (vb)                                mode = M_BLK;
      else if (mode == M_BLK)                mode = M_ACT;
      else if (mode == M_ACT && waited == MW) mode = M_FRC;
      else if (mode == M_FRC && cg)          mode = M_ACT;
      if (dg) d_pend = 1'b0;
      if (cg) c_pend = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic hold_both(input bit cpu_write);
    if (!d_pend) begin d_pend = 1'b1; d_addr = $urandom_range(0, 31); end
    if (!c_pend) begin
      c_pend = 1'b1; c_we = cpu_write; c_addr = 5; c_wd = $urandom_range(0, 255);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Scoreboard monitor: compare the DUT against each predicted cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant", {bus.disp_gnt, bus.cpu_gnt}, {e.dg, e.cg});
      chk("mem_en", bus.mem_en, e.mem.v);
      if (e.mem.v) begin
        chk("mem_we", bus.mem_we, e.mem.we);
        chk("mem_addr", bus.mem_addr, e.mem.addr);
        if (e.mem.we) chk("mem_wdata", bus.mem_wdata, e.mem.wdata);
      end
      chk("rvalid", {bus.disp_rvalid, bus.cpu_rvalid}, {e.drv, e.crv});
      if (e.drv) chk("disp_rdata", bus.disp_rdata, e.rdata);
      if (e.crv) chk("cpu_rdata", bus.cpu_rdata, e.rdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    vb = 0; d_pend = 0; c_pend = 0; c_we = 0; d_addr = 0; c_addr = 0; c_wd = 0;
    mode = M_ACT; waited = 0; h1 = '0; h2 = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 0;

    // Reset state.
    step(1'b0); step(1'b0);
    settle();
    chk("rst_outs", int'(|{bus.disp_gnt, bus.cpu_gnt, bus.disp_rvalid, bus.cpu_rvalid,
                           bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
    chk("rst_state", dut.state_q, ACTIVE);
    chk("rst_wait", int'(dut.u_starve.count_q), 0);

    // Preload addresses 0..31 through the arbiter (address 5 holds 0xA7).
    for (int i = 0; i < 32; i++) begin
      c_pend = 1'b1; c_we = 1'b1; c_addr = i;
      c_wd = (i == 5) ? 8'hA7 : ((i * 37 + 11) % 256);
      step(1'b1);
    end
    idle(2);

    // Both requesting in active video: 16 scanout grants, then one forced cpu.
    for (int i = 0; i < 51; i++) begin
      hold_both(1'b0);
      step(1'b1);
      settle();
      chk("pat_disp", bus.disp_gnt, (i % 17 != 16) ? 1 : 0);
      chk("pat_cpu", bus.cpu_gnt, (i % 17 == 16) ? 1 : 0);
    end

    // Blanking: cpu wins every cycle, scanout only when cpu is idle.
    vb = 1'b1;
    hold_both(1'b0); step(1'b1);
    for (int i = 0; i < 8; i++) begin
      hold_both(1'b0); step(1'b1); settle();
      chk("blank_cpu", {bus.disp_gnt, bus.cpu_gnt}, 2'b01);
    end
    d_pend = 1'b1; step(1'b1); settle();
    chk("blank_disp", {bus.disp_gnt, bus.cpu_gnt}, 2'b10);
    vb = 1'b0; idle(4);

    // vblank rises while the cpu is waiting.
    for (int i = 0; i < 8; i++) begin hold_both(1'b0); step(1'b1); end
    vb = 1'b1; hold_both(1'b0); step(1'b1);
    d_pend = 1'b1; step(1'b1); settle();
    chk("vb_cpu_gnt", bus.cpu_gnt, 1);
    chk("vb_state", dut.state_q, BLANK);
    chk("vb_wait_before", int'(dut.u_starve.count_q), 9);
    step(1'b1); settle();
    chk("vb_wait_clr", int'(dut.u_starve.count_q), 0);
    vb = 1'b0; idle(4);

    // Lone cpu read of 0x005.
    c_pend = 1'b1; c_we = 1'b0; c_addr = 5;
    step(1'b1); settle();
    chk("rd_gnt", bus.cpu_gnt, 1);
    step(1'b1); settle();
    chk("rd_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 10'h005});
    step(1'b1); settle();
    chk("rd_ret", {bus.cpu_rvalid, bus.disp_rvalid, bus.cpu_rdata}, {1'b1, 1'b0, 8'hA7});

    // cpu write 0x3C to 0x010, then scanout reads it back.
    c_pend = 1'b1; c_we = 1'b1; c_addr = 16; c_wd = 8'h3C;
    step(1'b1);
    d_pend = 1'b1; d_addr = 16;
    step(1'b1);
    step(1'b1); settle();
    chk("wr_norv", {bus.disp_rvalid, bus.cpu_rvalid}, 2'b00);
    step(1'b1); settle();
    chk("raw_ret", {bus.disp_rvalid, bus.disp_rdata}, {1'b1, 8'h3C});

    // Reset one cycle after a scanout read grant drops the return.
    d_pend = 1'b1; d_addr = 7;
    step(1'b1);
    step(1'b0); settle();
    chk("rst_mid_outs", int'(|{bus.disp_gnt, bus.cpu_gnt, bus.disp_rvalid, bus.cpu_rvalid,
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                               bus.disp_rdata, bus.cpu_rdata}), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1); settle();
      chk("rst_drop", bus.disp_rvalid, 0);
    end

    // Random traffic: first saturated, then sparse.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) vb = ~vb;
      if (!d_pend && (i < 1000 || $urandom_range(0, 2) == 0)) begin
        d_pend = 1'b1; d_addr = $urandom_range(0, 31);
      end
      if (!c_pend && (i < 1000 || $urandom_range(0, 2) == 0)) begin
        c_pend = 1'b1; c_we = $urandom_range(0, 1); c_addr = $urandom_range(0, 31);
        c_wd = $urandom_range(0, 255);
      end
      step(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
    end
    d_pend = 1'b0; c_pend = 1'b0; vb = 1'b0;
    idle(4);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 10, VRAM address width (tile map of up to 1024 entries).
REQ-002 Parameter DW, default 8, VRAM data width (tile index).
REQ-003 Parameter MAX_WAIT, default 16, maximum cycles the game-logic requester may wait during active video.
REQ-004 clk  in  1  pixel/system clock; the block has one clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 vblank  in  1  high while the display controller is outside the visible area.
REQ-007 disp_req  in  1  scanout read request; held until granted.
REQ-008 disp_addr  in  AW  scanout read address.
REQ-009 disp_gnt  out  1  scanout request accepted this cycle.
REQ-010 disp_rvalid  out  1  disp_rdata valid.
REQ-011 disp_rdata  out  DW  scanout read data.
REQ-012 cpu_req  in  1  game-logic request; held with stable fields until granted.
REQ-013 cpu_we  in  1  1 = write, 0 = read.
REQ-014 cpu_addr  in  AW  game-logic address.
REQ-015 cpu_wdata  in  DW  game-logic write data.
REQ-016 cpu_gnt  out  1  game-logic request accepted this cycle.
REQ-017 cpu_rvalid  out  1  cpu_rdata valid; read grants only.
REQ-018 cpu_rdata  out  DW  game-logic read data.
REQ-019 mem_en, mem_we  out  1 each  single-port VRAM enable and write strobe.
REQ-020 mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW (VRAM read latency: 1 cycle).

Function
REQ-021 Grant SHALL be decided combinationally, with at most one of disp_gnt/cpu_gnt high per cycle and a grant only when the matching req is high.
REQ-022 The FSM SHALL have states ACTIVE (display priority), BLANK (cpu priority) and FORCE (cpu priority for exactly one grant).
REQ-023 vblank=1 SHALL move any state to BLANK on the next edge; vblank=0 in BLANK SHALL move to ACTIVE.
REQ-024 ACTIVE SHALL move to FORCE when wait_cnt==MAX_WAIT and vblank=0; FORCE SHALL return to ACTIVE on the edge following cpu_gnt.
REQ-025 In every state, if only one requester is active it SHALL be granted.
REQ-026 wait_cnt (width clog2(MAX_WAIT+1)) SHALL increment when cpu_req && !cpu_gnt, saturate at MAX_WAIT, and clear on cpu_gnt or !cpu_req.
REQ-027 The granted access SHALL be registered onto mem_en/mem_we/mem_addr/mem_wdata one cycle after grant; mem_en=0 when nothing is granted.
REQ-028 For read grants, the matching rvalid SHALL pulse for one cycle exactly 2 cycles after the grant, with rdata equal to mem_rdata; a 2-stage owner-tag pipeline SHALL route returns.
REQ-029 Writes SHALL produce no rvalid; back-to-back grants SHALL sustain one access per cycle.
REQ-030 A change in vblank SHALL NOT cancel or reorder in-flight reads.

Reset
REQ-031 While reset_n=0: all outputs 0, state ACTIVE, wait_cnt 0, owner tags cleared.
REQ-032 Reset asserted with reads in flight SHALL drop those returns; no rvalid SHALL appear after release for pre-reset grants.

Structure
REQ-033 Package vram_pkg SHALL hold the AW/DW/MAX_WAIT defaults, the state enum (ACTIVE, BLANK, FORCE) and the owner-tag encoding (NONE, DISP, CPU).
REQ-034 The starvation counter SHALL be the sub-module vram_starve_cnt; all other logic SHALL be in vram_arbiter.

Verification
REQ-035 vblank=0, disp_req and cpu_req held high continuously -> 16 disp_gnt, then 1 cpu_gnt in FORCE, repeating.
REQ-036 vblank=1, both requesting -> cpu_gnt every cycle, and disp_gnt only in cycles when cpu_req=0.
REQ-037 cpu read of addr 0x005 holding 0xA7, with nothing else requesting -> mem_en at grant+1, cpu_rvalid=1 with cpu_rdata=0xA7 at grant+2, and disp_rvalid stays 0.
REQ-038 cpu write 0x3C to 0x010, then disp read of 0x010 -> disp_rdata=0x3C; the write produces no rvalid.
REQ-039 reset_n pulsed low one cycle after a disp read grant -> outputs 0 during reset, and no disp_rvalid afterward.
REQ-040 vblank rises during a FORCE wait -> state BLANK, cpu granted, and wait_cnt cleared.
